// File: rtl/expand_pkg.sv
// Shared parameters, FSM state type and saturating adder for the expand block.
// The adder is only referenced when EXPAND_RESIDUAL_EN is defined.
package expand_pkg;

    localparam int DIM = 16;
    localparam int DW  = 8;
    localparam int CW  = $clog2(DIM);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        DONE
    } expand_state_t;

    // Add in DW+1 bits; the top two bits disagree only on overflow.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        case (s[DW:DW-1])
            2'b01:   sat_add = {1'b0, {(DW-1){1'b1}}};
            2'b10:   sat_add = {1'b1, {(DW-1){1'b0}}};
            default: sat_add = s[DW-1:0];
        endcase
    endfunction

endpackage

// File: rtl/expand.sv
// Broadcasts a latched vector down every row of a DIM x DIM matrix, one element per cycle.
// EXPAND_RESIDUAL_EN adds a matrix_res port and writes sat(matrix_res + vector) instead.
//   state | meaning
//   IDLE  | waiting for enable
//   LOAD  | latch vector_in, clear counters
//   FILL  | write one element per cycle, column-major
//   DONE  | pass complete, done pulses next cycle
module expand
    import expand_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [DIM-1:0][DW-1:0]           vector_in,
`ifdef EXPAND_RESIDUAL_EN
    input  logic [DIM-1:0][DIM-1:0][DW-1:0]  matrix_res,
`endif
    output logic [DIM-1:0][DIM-1:0][DW-1:0]  matrix_out,
    output logic                             done
);

    expand_state_t           state, state_nxt;
    logic [CW-1:0]           row_cnt, col_cnt;
    logic [DIM-1:0][DW-1:0]  vec_q;
    logic                    load, wr, last;
    logic [DW-1:0]           elem;

    assign last = (row_cnt == CW'(DIM-1)) && (col_cnt == CW'(DIM-1));

`ifdef EXPAND_RESIDUAL_EN
    assign elem = sat_add(matrix_res[row_cnt][col_cnt], vec_q[col_cnt]);
`else
    assign elem = vec_q[col_cnt];
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE: if (enable) state_nxt = LOAD;
            LOAD: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    load      = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    wr = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters only advance while writing; any other state leaves them cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            col_cnt    <= '0;
            vec_q      <= '0;
            matrix_out <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == DONE);
            if (load) vec_q <= vector_in;
            if (wr) begin
                matrix_out[row_cnt][col_cnt] <= elem;
                row_cnt <= row_cnt + 1'b1;
                if (row_cnt == CW'(DIM-1)) col_cnt <= col_cnt + 1'b1;
            end else begin
                row_cnt <= '0;
                col_cnt <= '0;
            end
        end
    end

endmodule
